// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - data/fetch SRAM arbiter with strobe sequencing; ARB_PERF_EN adds perf_stall_cnt
module mem_arbiter #(
   parameter int ACCESS_CYCLES = 1,
   parameter int WE_PULSE      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] b_addr,
   output logic [15:0] b_rdata,
   output logic        b_ready,
   input  logic [15:0] a_addr,
   input  logic [15:0] a_wdata,
   input  logic [1:0]  a_ctrl,
   output logic [15:0] a_rdata,
   output logic        a_ready,
   output logic        stall,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   output logic        ram_drive
`ifdef ARB_PERF_EN
   ,
   output logic [15:0] perf_stall_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE, A_READ, A_WR_SETUP, A_WR_PULSE, A_WR_HOLD, B_READ
   } state_t;

   localparam logic [1:0] AC_LAST = 2'(ACCESS_CYCLES - 1);
   localparam logic [1:0] WE_LAST = 2'(WE_PULSE - 1);

   state_t      state, state_nx;
   logic [1:0]  cnt, cnt_nx;
   logic [15:0] addr_nx, wdata_nx;
   logic [15:0] b_hold;
   logic        a_cap, b_cap;

   // State, counter and SRAM address/data registers; reset parks the bus idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         ram_addr  <= 16'h0000;
         ram_wdata <= 16'h0000;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         ram_addr  <= addr_nx;
         ram_wdata <= wdata_nx;
      end
   end

   // Next state, address/data load and strobe decode; IDLE doubles as bus turnaround
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      addr_nx   = ram_addr;
      wdata_nx  = ram_wdata;
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      a_cap     = 1'b0;
      b_cap     = 1'b0;
      ram_ce_n  = 1'b1;
      ram_oe_n  = 1'b1;
      ram_we_n  = 1'b1;
      ram_drive = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = 2'd0;
            case (a_ctrl)
               2'b01: begin
                  addr_nx  = a_addr;
                  state_nx = A_READ;
               end
               2'b10: begin
                  addr_nx  = a_addr;
                  wdata_nx = a_wdata;
                  state_nx = A_WR_SETUP;
               end
               default: begin
                  addr_nx  = b_addr;
                  state_nx = B_READ;
               end
            endcase
         end
         A_READ: begin
            ram_ce_n = 1'b0;
            ram_oe_n = 1'b0;
            if (cnt == AC_LAST) begin
               a_ready  = 1'b1;
               a_cap    = 1'b1;
               cnt_nx   = 2'd0;
               addr_nx  = b_addr;
               state_nx = B_READ;
            end else begin
               cnt_nx = cnt + 2'd1;
            end
         end
         A_WR_SETUP: begin
            ram_ce_n  = 1'b0;
            ram_drive = 1'b1;
            cnt_nx    = 2'd0;
            state_nx  = A_WR_PULSE;
         end
         A_WR_PULSE: begin
            ram_ce_n  = 1'b0;
            ram_we_n  = 1'b0;
            ram_drive = 1'b1;
            if (cnt == WE_LAST) begin
               cnt_nx   = 2'd0;
               state_nx = A_WR_HOLD;
            end else begin
               cnt_nx = cnt + 2'd1;
            end
         end
         A_WR_HOLD: begin
            ram_ce_n  = 1'b0;
            ram_drive = 1'b1;
            a_ready   = 1'b1;
            cnt_nx    = 2'd0;
            addr_nx   = b_addr;
            state_nx  = B_READ;
         end
         B_READ: begin
            ram_ce_n = 1'b0;
            ram_oe_n = 1'b0;
            if (cnt == AC_LAST) begin
               b_ready  = 1'b1;
               b_cap    = 1'b1;
               cnt_nx   = 2'd0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 2'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 2'd0;
         end
      endcase
   end

   // Load result and fetched-instruction hold registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_rdata <= 16'h0000;
         b_hold  <= 16'h0000;
      end else begin
         if (a_cap) a_rdata <= ram_rdata;
         if (b_cap) b_hold  <= ram_rdata;
      end
   end

   assign b_rdata = (state == B_READ) ? ram_rdata : b_hold;
   assign stall   = ~b_ready;

`ifdef ARB_PERF_EN
   // Saturating count of stalled cycles since reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt <= 16'h0000;
      end else if (stall && (perf_stall_cnt != 16'hFFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external 16-bit asynchronous SRAM between the CPU's two memory ports: data port A (MEM stage) and instruction-fetch port B (IF stage).
- Sequences the multi-cycle SRAM read and write strobes.
- Data accesses have priority over fetches.
- Drives a pipeline stall so that the whole CPU advances only when an instruction fetch completes.

Parameters:
- ACCESS_CYCLES, 1, cycles OE is held low per read (legal 1..4)
- WE_PULSE, 1, cycles WE is held low per write (legal 1..4)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- b_addr  in  16  fetch address (next PC)
- b_rdata  out  16  fetched instruction
- b_ready  out  1  high in the final B_READ cycle; pipeline advances at that edge
- a_addr  in  16  data address
- a_wdata  in  16  store data
- a_ctrl  in  2  00 none, 01 read, 10 write, 11 reserved (treated as 00)
- a_rdata  out  16  load result, held until the next data read completes
- a_ready  out  1  high in the final cycle of a data access
- stall  out  1  equals NOT b_ready
- ram_addr  out  16  SRAM address (registered)
- ram_wdata  out  16  SRAM write data (registered)
- ram_rdata  in  16  SRAM read data
- ram_ce_n  out  1  chip enable, active-low
- ram_oe_n  out  1  output enable, active-low
- ram_we_n  out  1  write enable, active-low
- ram_drive  out  1  tristate enable for ram_wdata onto the data bus

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, counters 0
  - ram_ce_n, ram_oe_n, ram_we_n = 1; ram_drive = 0
  - ram_addr, ram_wdata, a_rdata, b_rdata hold register = 0
  - a_ready = b_ready = 0, so stall = 1
- States: IDLE, A_READ, A_WR_SETUP, A_WR_PULSE, A_WR_HOLD, B_READ.
- IDLE (arbitration and bus turnaround, 1 cycle; all strobes high):
  - a_ctrl=01: load ram_addr <= a_addr, go to A_READ.
  - a_ctrl=10: load ram_addr <= a_addr and ram_wdata <= a_wdata, go to A_WR_SETUP.
  - Otherwise: load ram_addr <= b_addr, go to B_READ.
- A_READ:
  - ce_n = 0, oe_n = 0 for ACCESS_CYCLES cycles.
  - a_ready is high in the last cycle; a_rdata <= ram_rdata at that edge.
  - Then ram_addr <= b_addr and go to B_READ.
- Write sequence (ram_drive = 1 and oe_n = 1 throughout):
  - A_WR_SETUP: ce_n = 0, we_n = 1, 1 cycle.
  - A_WR_PULSE: we_n = 0 for WE_PULSE cycles.
  - A_WR_HOLD: we_n = 1, 1 cycle; a_ready is high here.
  - Then ram_addr <= b_addr and go to B_READ.
- B_READ:
  - ce_n = 0, oe_n = 0 for ACCESS_CYCLES cycles.
  - b_rdata = ram_rdata combinationally while in B_READ; the hold register captures it at the final edge and drives b_rdata in all other states.
  - b_ready is high in the final cycle; next state is IDLE.
- Latency per instruction:
  - Fetch only: 1 + ACCESS_CYCLES cycles.
  - With load: 1 + 2*ACCESS_CYCLES cycles.
  - With store: 3 + WE_PULSE + ACCESS_CYCLES cycles.
- The CPU holds a_addr, a_wdata, a_ctrl and b_addr stable while stall=1. The arbiter samples them only in IDLE and does not re-check them mid-access.
- Invariants:
  - oe_n and we_n are never both low.
  - ram_drive is never high while oe_n is low.
  - ce_n is high only in IDLE.
- A store followed by a fetch of the same address returns the newly written value, because the write completes before the fetch.
- Reset asserted mid-access aborts immediately and asynchronously; WE is never left low.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined: adds output perf_stall_cnt (16 bits).
  - Increments every cycle with stall=1 after reset release.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 with random inputs -> ram_ce_n/oe_n/we_n = 1, ram_drive = 0, stall = 1, a_rdata = b_rdata = 16'h0000.
- Fetch only (a_ctrl=00, b_addr=16'h0000, RAM model returns 16'h0800) -> b_ready high on the 2nd cycle after rst release, b_rdata = 16'h0800, oe_n low exactly 1 cycle, b_ready repeats every 2 cycles.
- Load (a_ctrl=01, a_addr=16'h8000 -> 16'h1234; b_addr=16'h0002 -> 16'h1044) -> IDLE, A_READ (a_ready, a_rdata = 16'h1234), B_READ (b_ready, b_rdata = 16'h1044); 3 cycles.
- Store then fetch (a_ctrl=10, a_addr=b_addr=16'h0004, a_wdata=16'hBEEF):
  - we_n low for 1 cycle with ram_drive = 1 and oe_n = 1 throughout.
  - The following fetch returns b_rdata = 16'hBEEF; 5 cycles total.
- Reset mid-write (rst -> 0 during A_WR_PULSE, between clock edges) -> we_n = 1 and ram_drive = 0 immediately; IDLE after release.
- a_ctrl=11 with ACCESS_CYCLES=2 -> treated as fetch only, b_ready every 3 cycles; with ARB_PERF_EN, perf_stall_cnt = 2 after the first fetch completes.
